// File: rtl/drawing_control.sv
// Control FSM for the drawing datapath: owns the cursor cell, turns buttons into
// datapath commands and steps the datapath through its oState/iDone/iMove handshake.
module drawing_control #(
    parameter int SCREEN_WIDTH   = 640,
    parameter int SCREEN_HEIGHT  = 480,
    parameter int CELL_DIMENSION = 5,
    parameter int UPPER_BITS     = $clog2(((SCREEN_WIDTH / CELL_DIMENSION) > (SCREEN_HEIGHT / CELL_DIMENSION)) ?
                                          (SCREEN_WIDTH / CELL_DIMENSION) : (SCREEN_HEIGHT / CELL_DIMENSION)),
    parameter int WAIT_CYCLES    = 4
) (
    input  logic                  iClk,
    input  logic                  iResetn,
    input  logic                  iUp,
    input  logic                  iDown,
    input  logic                  iLeft,
    input  logic                  iRight,
    input  logic                  iDraw,
    input  logic                  iErase,
    input  logic                  iClear,
    input  logic                  iMove,
    input  logic                  iDone,
    output logic [2:0]            oState,
    output logic [UPPER_BITS-1:0] oX_cell,
    output logic [UPPER_BITS-1:0] oY_cell,
    output logic                  oBusy
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [UPPER_BITS-1:0] X_MAX = UPPER_BITS'(SCREEN_WIDTH / CELL_DIMENSION - 1);
    localparam logic [UPPER_BITS-1:0] Y_MAX = UPPER_BITS'(SCREEN_HEIGHT / CELL_DIMENSION - 1);
    localparam logic [UPPER_BITS-1:0] ONE   = UPPER_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MOVE  = 3'd1,
        S_WAIT  = 3'd2,
        S_CLEAN = 3'd3,
        S_DRAW  = 3'd4,
        S_ERASE = 3'd5,
        S_CLEAR = 3'd6
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             up_q, down_q, left_q, right_q, clear_q;

    wire up_p    = iUp    & ~up_q;
    wire down_p  = iDown  & ~down_q;
    wire left_p  = iLeft  & ~left_q;
    wire right_p = iRight & ~right_q;
    wire clear_p = iClear & ~clear_q;

    assign oState = state;
    assign oBusy  = (state != S_IDLE);

    // History resets high so a button held through reset does not register as a press.
    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            oX_cell  <= '0;
            oY_cell  <= '0;
            up_q     <= 1'b1;
            down_q   <= 1'b1;
            left_q   <= 1'b1;
            right_q  <= 1'b1;
            clear_q  <= 1'b1;
        end else begin
            up_q    <= iUp;
            down_q  <= iDown;
            left_q  <= iLeft;
            right_q <= iRight;
            clear_q <= iClear;
            case (state)
                S_IDLE: begin
                    // iDone still high means the datapath has not yet dropped its last completion.
                    if (!iDone && clear_p)     state <= S_CLEAR;
                    else if (!iDone && iMove)  state <= S_MOVE;
                    else if (!iDone && iDraw)  state <= S_DRAW;
                    else if (!iDone && iErase) state <= S_ERASE;
                    else begin
                        if (up_p) begin
                            if (oY_cell != '0) oY_cell <= oY_cell - ONE;
                        end else if (down_p) begin
                            if (oY_cell != Y_MAX) oY_cell <= oY_cell + ONE;
                        end
                        if (left_p) begin
                            if (oX_cell != '0) oX_cell <= oX_cell - ONE;
                        end else if (right_p) begin
                            if (oX_cell != X_MAX) oX_cell <= oX_cell + ONE;
                        end
                    end
                end
                S_MOVE: if (iDone) state <= S_WAIT;
                S_WAIT: begin
                    if (wait_cnt == CNT_W'(WAIT_CYCLES - 1)) begin
                        wait_cnt <= '0;
                        state    <= S_CLEAN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_CLEAN, S_DRAW, S_ERASE, S_CLEAR: if (iDone) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_drawing_control.sv
// Directed vector bench for drawing_control: a table of per-cycle inputs and
// expected outputs, plus hand sequences for reset behaviour.
module tb_drawing_control;

    localparam logic [8:0] U  = 9'h100, D  = 9'h080, L  = 9'h040, R  = 9'h020,
                           DR = 9'h010, ER = 9'h008, CL = 9'h004, MV = 9'h002,
                           DN = 9'h001, NO = 9'h000;

    typedef struct {
        logic [8:0] in;
        logic [2:0] st;
        logic [6:0] x;
        logic [6:0] y;
    } vec_t;

    logic       iClk = 1'b0;
    logic       iResetn;
    logic       iUp, iDown, iLeft, iRight, iDraw, iErase, iClear, iMove, iDone;
    logic [2:0] oState;
    logic [6:0] oX_cell, oY_cell;
    logic       oBusy;

    int   errors = 0;
    int   checks = 0;
    vec_t vt[$];

    drawing_control dut (
        .iClk(iClk), .iResetn(iResetn),
        .iUp(iUp), .iDown(iDown), .iLeft(iLeft), .iRight(iRight),
        .iDraw(iDraw), .iErase(iErase), .iClear(iClear),
        .iMove(iMove), .iDone(iDone),
        .oState(oState), .oX_cell(oX_cell), .oY_cell(oY_cell), .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    task automatic add(input logic [8:0] in, input int st, input int x, input int y);
        vec_t v;
        v.in = in;
        v.st = 3'(st);
        v.x  = 7'(x);
        v.y  = 7'(y);
        vt.push_back(v);
    endtask

    task automatic drive(input logic [8:0] in);
        {iUp, iDown, iLeft, iRight, iDraw, iErase, iClear, iMove, iDone} = in;
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic check(input string name, input int st, input int x, input int y);
        logic exp_busy;
        exp_busy = (st != 0);
        checks++;
        if (oState !== 3'(st) || oX_cell !== 7'(x) || oY_cell !== 7'(y) || oBusy !== exp_busy) begin
            errors++;
            $display("FAIL %s: got state=%0d x=%0d y=%0d busy=%0b, want state=%0d x=%0d y=%0d busy=%0b",
                     name, oState, oX_cell, oY_cell, oBusy, st, x, y, exp_busy);
        end
    endtask

    initial begin
        // Move sequence; Right is held through reset first and must not fire.
        add(R, 0, 0, 0);  add(R, 0, 0, 0);  add(NO, 0, 0, 0);
        add(R, 0, 1, 0);  add(NO, 0, 1, 0);
        add(MV, 1, 1, 0); add(MV, 1, 1, 0); add(MV | DN, 2, 1, 0);
        add(MV, 2, 1, 0); add(NO, 2, 1, 0); add(DN, 2, 1, 0);
        add(NO, 3, 1, 0); add(DN, 0, 1, 0); add(NO, 0, 1, 0);
        // Saturation and simultaneous presses
        add(U, 0, 1, 0);  add(NO, 0, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            add(D, 0, 1, i); add(NO, 0, 1, i);
        end
        add(U | D, 0, 1, 4); add(NO, 0, 1, 4);
        add(L | D, 0, 0, 5); add(NO, 0, 0, 5);
        add(L, 0, 0, 5);     add(NO, 0, 0, 5);
        for (int i = 1; i <= 127; i++) begin
            add(R, 0, i, 5); add(NO, 0, i, 5);
        end
        add(R, 0, 127, 5);     add(NO, 0, 127, 5);
        add(L | R, 0, 126, 5); add(NO, 0, 126, 5);
        // A press in the cycle IDLE is left is dropped
        add(R | DR, 4, 126, 5); add(DN, 0, 126, 5); add(NO, 0, 126, 5);
        // Draw held re-enters after iDone drops
        add(DR, 4, 126, 5); add(DR | DN, 0, 126, 5); add(DR | DN, 0, 126, 5);
        add(DR, 4, 126, 5); add(DN, 0, 126, 5);      add(NO, 0, 126, 5);
        // Erase, and draw over erase
        add(ER, 5, 126, 5); add(DN, 0, 126, 5); add(DR | ER, 4, 126, 5);
        add(DN, 0, 126, 5); add(NO, 0, 126, 5);
        // Clear wins; a press during CLEAR is lost; held clear does not re-fire
        add(CL | MV | DR, 6, 126, 5); add(CL | L, 6, 126, 5); add(CL, 6, 126, 5);
        add(CL | DN, 0, 126, 5);      add(CL, 0, 126, 5);     add(NO, 0, 126, 5);
        // iMove blocked while iDone high in IDLE
        add(MV | DN, 0, 126, 5); add(MV, 1, 126, 5); add(DN, 2, 126, 5);
        add(NO, 2, 126, 5); add(NO, 2, 126, 5); add(NO, 2, 126, 5);
        add(NO, 3, 126, 5); add(DN, 0, 126, 5); add(NO, 0, 126, 5);

        iResetn = 1'b0;
        drive(R);
        step();
        check("reset_hold", 0, 0, 0);
        step();
        @(negedge iClk);
        iResetn = 1'b1;

        foreach (vt[i]) begin
            string nm;
            drive(vt[i].in);
            step();
            nm = $sformatf("vec%0d", i);
            check(nm, vt[i].st, vt[i].x, vt[i].y);
        end

        // Reset in the middle of WAIT, counter at 2
        drive(MV);      step(); check("mw_move", 1, 126, 5);
        drive(MV | DN); step(); check("mw_wait0", 2, 126, 5);
        drive(NO);      step(); check("mw_wait1", 2, 126, 5);
        step();                 check("mw_wait2", 2, 126, 5);
        #2 iResetn = 1'b0;
        #1 check("mw_async_reset", 0, 0, 0);
        @(negedge iClk);
        iResetn = 1'b1;
        drive(MV); step(); check("rw_move", 1, 0, 0);
        drive(DN); step(); check("rw_wait_a", 2, 0, 0);
        drive(NO); step(); check("rw_wait_b", 2, 0, 0);
        step();            check("rw_wait_c", 2, 0, 0);
        step();            check("rw_wait_d", 2, 0, 0);
        step();            check("rw_clean", 3, 0, 0);
        drive(DN); step(); check("rw_idle", 0, 0, 0);
        drive(NO); step(); check("rw_idle2", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
